// File: rtl/sio_pkg.sv
// Shared types and constants for the single-wire serial responder.
package sio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        TURN,
        TX_START,
        TX_DATA,
        TX_STOP
    } state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sio_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module sio_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sio_responder.sv
// Half-duplex single-wire serial responder: receives a byte, optionally replies after a turnaround.
// Build option SIO_PUSH_PULL_EN: actively drive 1 bits and the stop bit instead of releasing the line.
module sio_responder
    import sio_pkg::*;
#(
    parameter int BIT_CYC  = 8,
    parameter int TURN_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    inout  wire        io,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy
);

    localparam int CW = $clog2(BIT_CYC);
    localparam int BW = $clog2(DATA_BITS);
    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] CYC_MID   = CW'(BIT_CYC / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

    state_t                 state, state_nxt;
    logic                   line_s, line_q;
    logic [CW-1:0]          cyc_cnt;
    logic [TW-1:0]          turn_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   sh;
    logic                   cyc_last;
    logic                   cyc_clr, shift_en, tx_shift, rx_load, err_set, tx_take;
    logic                   drv_en, drv_val;

    sio_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (io),
        .q     (line_s)
    );

    assign cyc_last = (cyc_cnt == CYC_LAST);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cyc_clr   = 1'b0;
        shift_en  = 1'b0;
        tx_shift  = 1'b0;
        rx_load   = 1'b0;
        err_set   = 1'b0;
        tx_take   = 1'b0;
        drv_en    = 1'b0;
        drv_val   = 1'b1;
        case (state)
            IDLE: begin
                if (line_q && !line_s) begin
                    state_nxt = RX_START;
                    cyc_clr   = 1'b1;
                end
            end
            RX_START: begin
                // Mid start bit: a line back high means it was only a glitch.
                if (cyc_cnt == CYC_MID) begin
                    cyc_clr   = 1'b1;
                    state_nxt = (line_s == START_BIT) ? RX_DATA : IDLE;
                end
            end
            RX_DATA: begin
                if (cyc_last) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT)
                        state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cyc_last) begin
                    if (line_s == STOP_BIT) begin
                        rx_load = 1'b1;
                        if (tx_valid) begin
                            tx_take   = 1'b1;
                            state_nxt = TURN;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            TURN: begin
                if (turn_cnt == TURN_LAST) begin
                    state_nxt = TX_START;
                    cyc_clr   = 1'b1;
                end
            end
            TX_START: begin
                drv_en  = 1'b1;
                drv_val = START_BIT;
                if (cyc_last)
                    state_nxt = TX_DATA;
            end
            TX_DATA: begin
                drv_en  = 1'b1;
                drv_val = sh[0];
                if (cyc_last) begin
                    tx_shift = 1'b1;
                    if (bit_cnt == LAST_BIT)
                        state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                drv_en  = 1'b1;
                drv_val = STOP_BIT;
                if (cyc_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            line_q    <= 1'b1;
            cyc_cnt   <= '0;
            turn_cnt  <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            tx_ready  <= 1'b0;
        end else begin
            state    <= state_nxt;
            line_q   <= line_s;
            cyc_cnt  <= (cyc_clr || cyc_last) ? '0 : cyc_cnt + 1'b1;
            turn_cnt <= (state == TURN) ? turn_cnt + 1'b1 : '0;
            if (state == IDLE)
                bit_cnt <= '0;
            else if (shift_en || tx_shift)
                bit_cnt <= bit_cnt + 1'b1;
            // One register serves as RX deserializer, then as TX serializer once the reply is taken.
            if (shift_en)
                sh <= {line_s, sh[DATA_BITS-1:1]};
            else if (tx_take)
                sh <= tx_data;
            else if (tx_shift)
                sh <= sh >> 1;
            if (rx_load)
                rx_data <= sh;
            rx_valid  <= rx_load;
            frame_err <= err_set;
            tx_ready  <= tx_take;
        end
    end

    // Gated by rst_n so that reset releases the pad without waiting for a clock.
`ifdef SIO_PUSH_PULL_EN
    assign io = (rst_n && drv_en) ? drv_val : 1'bz;
`else
    assign io = (rst_n && drv_en && !drv_val) ? 1'b0 : 1'bz;
`endif

endmodule

// File: tb/tb_sio_responder.sv
// Self-checking bench for sio_responder: directed frame table, randomized frames, reset/glitch corners.
module tb_sio_responder;

    localparam int BIT_CYC  = 8;
    localparam int TURN_CYC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       drv_low = 1'b0;
    wire        io;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, frame_err, tx_valid, tx_ready, busy;

    pullup (io);
    assign io = drv_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    sio_responder #(.BIT_CYC(BIT_CYC), .TURN_CYC(TURN_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io        (io),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // Event monitor: counts pulses and records when they happen.
    int         cyc = 0, n_rxv = 0, n_err = 0, n_txr = 0, n_low = 0;
    int         t_rxv = 0, t_txr = 0, t_low = 0;
    logic [7:0] last_rx = 8'h00;
    logic       want_low = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (rx_valid) begin n_rxv++; last_rx = rx_data; t_rxv = cyc; end
            if (frame_err) n_err++;
            if (tx_ready) begin n_txr++; t_txr = cyc; want_low = 1'b1; end
            if (io == 1'b0 && !drv_low) begin
                n_low++;
                if (want_low) begin t_low = cyc; want_low = 1'b0; end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        drv_low = ~v;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        drv_low = 1'b0;
    endtask

    task automatic wait_dut_low(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * BIT_CYC; i++) begin
            @(negedge clk);
            if (io == 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_frame(input string nm, input logic [7:0] b, input logic stop,
                             input logic txv, input logic [7:0] txd,
                             input logic e_valid, input logic [7:0] e_data,
                             input logic e_err, input logic e_reply);
        int         rxv0, err0, txr0, low0;
        logic       ok, stop_s, busy_mid;
        logic [7:0] got;
        rxv0 = n_rxv; err0 = n_err; txr0 = n_txr; low0 = n_low;
        tx_valid = txv;
        tx_data  = txd;
        send_frame(b, stop);
        if (e_reply) begin
            wait_dut_low(ok);
            check({nm, " reply_start_seen"}, 32'(ok), 32'd1);
            if (ok) begin
                repeat (BIT_CYC / 2) @(negedge clk);
                check({nm, " reply_start_mid"}, 32'(io), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CYC) @(negedge clk);
                    got[i] = io;
                end
                repeat (BIT_CYC) @(negedge clk);
                stop_s   = io;
                busy_mid = busy;
                repeat (BIT_CYC / 2 + 1) @(negedge clk);
                check({nm, " reply_byte"}, 32'(got), 32'(txd));
                check({nm, " reply_stop"}, 32'(stop_s), 32'd1);
                check({nm, " busy_in_stop"}, 32'(busy_mid), 32'd1);
                check({nm, " busy_after_stop"}, 32'(busy), 32'd0);
                check({nm, " turn_gap"}, 32'(t_low - t_txr), 32'(TURN_CYC));
                check({nm, " rxv_with_txr"}, 32'(t_rxv - t_txr), 32'd0);
            end
        end else begin
            repeat (3 * BIT_CYC) @(negedge clk);
            check({nm, " no_dut_drive"}, 32'(n_low - low0), 32'd0);
            check({nm, " idle_busy"}, 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check({nm, " rx_valid_pulses"}, 32'(n_rxv - rxv0), 32'(e_valid));
        check({nm, " rx_data"}, 32'(rx_data), 32'(e_data));
        if (e_valid) check({nm, " rx_data_at_pulse"}, 32'(last_rx), 32'(e_data));
        check({nm, " frame_err_pulses"}, 32'(n_err - err0), 32'(e_err));
        check({nm, " tx_ready_pulses"}, 32'(n_txr - txr0), 32'(e_reply));
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       txv;
        logic [7:0] txd;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_err;
        logic       e_reply;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic       ok, seen, stop;
        logic       txv;
        logic [7:0] b, txd, model_rx;
        int         rxv0, err0, txr0;

        tbl[0] = '{8'hA5, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b1, 8'hC3, 1'b1, 8'h3C, 1'b0, 1'b1};
        tbl[2] = '{8'h0F, 1'b0, 1'b1, 8'h55, 1'b0, 8'h3C, 1'b1, 1'b0};
        tbl[3] = '{8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[4] = '{8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b1};
        tbl[5] = '{8'h81, 1'b1, 1'b0, 8'h7E, 1'b1, 8'h81, 1'b0, 1'b0};

        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset state, then release reset in the middle of an all-ones frame.
        repeat (3) @(posedge clk); #1;
        check("reset_outputs", 32'({io, rx_data, rx_valid, frame_err, tx_ready, busy}), 32'h1000);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst_n = 1'b1;
        rxv0 = n_rxv;
        seen = 1'b0;
        for (int i = 0; i < 7 * BIT_CYC; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("midframe_release_busy", 32'(seen), 32'd0);
        check("midframe_release_io", 32'(io), 32'd1);
        check("midframe_release_rxv", 32'(n_rxv - rxv0), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            run_frame($sformatf("tbl%0d", i), tbl[i].b, tbl[i].stop, tbl[i].txv, tbl[i].txd,
                      tbl[i].e_valid, tbl[i].e_data, tbl[i].e_err, tbl[i].e_reply);

        // Two-cycle low glitch on an idle line, with tx_valid held high meanwhile.
        rxv0 = n_rxv; err0 = n_err; txr0 = n_txr;
        tx_valid = 1'b1;
        tx_data  = 8'h99;
        drv_low  = 1'b1;
        repeat (2) @(posedge clk); #1;
        drv_low = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < BIT_CYC / 2 + 3; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("glitch_detected", 32'(seen), 32'd1);
        check("glitch_busy_clear", 32'(busy), 32'd0);
        repeat (2 * BIT_CYC) @(negedge clk);
        check("glitch_no_pulses", 32'({n_rxv - rxv0, n_err - err0, n_txr - txr0}), 32'd0);
        @(posedge clk); #1;
        tx_valid = 1'b0;

        // Randomized frames against the rule-level model.
        model_rx = 8'h81;
        for (int k = 0; k < 12; k++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            txv  = 1'($urandom_range(0, 1));
            txd  = 8'($urandom);
            if (stop) model_rx = b;
            run_frame($sformatf("rand%0d", k), b, stop, txv, txd,
                      stop, model_rx, !stop, stop && txv);
        end

        // Reset while the responder is driving a 0 data bit.
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        send_frame(8'h5A, 1'b1);
        wait_dut_low(ok);
        check("rst_tx_start_seen", 32'(ok), 32'd1);
        repeat (BIT_CYC + BIT_CYC / 2) @(negedge clk);
        check("rst_tx_bit0_low", 32'({io, busy}), 32'b01);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_tx_released", 32'({io, rx_data, rx_valid, frame_err, tx_ready, busy}), 32'h1000);
        tx_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2 * BIT_CYC) @(posedge clk); #1;
        check("rst_tx_after", 32'({io, busy}), 32'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
